// File: rtl/encrypt_packetizer_pkg.sv
// Shared configuration for the encryption datapath: frame FSM states and
// default framing constants used by the packetizer stage.
package encrypt_config;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        LEN,
        PAYLOAD,
        CSUM
    } pkt_state_t;

    localparam logic [7:0] DEF_SOF_BYTE   = 8'hA5;
    localparam int         DEF_PKT_LEN    = 8;
    localparam int         DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/encrypt_packetizer_if.sv
// Byte-stream signals of the packetizer: ciphertext input (no backpressure)
// and the framed output toward the link stage.
// Output handshake: a byte moves on a rising clk edge where out_valid and
// out_ready are both 1; once out_valid is raised, out_valid and out_data hold
// until that transfer happens, and out_valid never depends on out_ready.
interface encrypt_packetizer_if;
    logic [7:0] din;
    logic       din_v;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // Environment side: feeds ciphertext and accepts frame bytes.
    modport master (
        output din, din_v, out_ready,
        input  out_data, out_valid
    );

    // Packetizer side.
    modport slave (
        input  din, din_v, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/encrypt_packetizer_fifo.sv
// Synchronous 8-bit ciphertext FIFO. Head is read straight from storage at
// the read pointer, so it is stable until a pop. Callers gate push/pop with
// full/empty; level is registered and counts 0..DEPTH inclusive.
module cipher_byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Pointer and level update; pointers wrap naturally at a power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state register; reset empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/encrypt_packetizer.sv
// Packetizer: buffers the encrypt unit's ciphertext and emits frames
// {SOF, LEN, payload[LEN], CSUM} where CSUM is the XOR of the payload bytes.
// A frame starts once PKT_LEN bytes are buffered, or earlier on flush.
module encrypt_packetizer
    import encrypt_config::*;
#(
    parameter  int         FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int         PKT_LEN    = DEF_PKT_LEN,
    parameter  logic [7:0] SOF_BYTE   = DEF_SOF_BYTE,
    localparam int         LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    encrypt_packetizer_if.slave  bus,
    input  logic                 flush,
    input  logic                 clear_ovf,
    output logic [LW-1:0]        fifo_level,
    output logic                 overflow,
    output logic                 busy,
    output pkt_state_t           state_dbg
);

    localparam logic [LW-1:0] PKT_LEN_L = LW'(PKT_LEN);

    pkt_state_t    state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    csum_q, csum_d;
    logic          flush_pend_q, flush_pend_d;
    logic          overflow_q, overflow_d;

    logic [7:0]    head;
    logic          full, empty;
    logic [LW-1:0] level;
    logic          push, pop, hs;

    // Upstream cannot stall: a byte arriving while full is lost.
    assign push = bus.din_v & ~full;
    // Handshake built from registered state so out_ready never feeds out_valid.
    assign hs   = (state_q != IDLE) & bus.out_ready;
    assign pop  = (state_q == PAYLOAD) & hs;

    cipher_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bus.din),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Frame sequencing, length latch, checksum, flush and overflow bookkeeping.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        csum_d       = csum_q;
        flush_pend_d = flush_pend_q | flush;
        overflow_d   = overflow_q;
        bus.out_valid = (state_q != IDLE);
        bus.out_data  = 8'h00;

        if (clear_ovf)          overflow_d = 1'b0;
        if (bus.din_v && full)  overflow_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (level >= PKT_LEN_L) begin
                    state_d = SOF;
                    len_d   = 8'(PKT_LEN);
                    cnt_d   = 8'h00;
                    csum_d  = 8'h00;
                end else if (flush_pend_q) begin
                    // A flush seen with nothing buffered is simply dropped.
                    flush_pend_d = flush;
                    if (!empty) begin
                        state_d = SOF;
                        len_d   = 8'(level);
                        cnt_d   = 8'h00;
                        csum_d  = 8'h00;
                    end
                end
            end
            SOF: begin
                bus.out_data = SOF_BYTE;
                if (hs) state_d = LEN;
            end
            LEN: begin
                bus.out_data = len_q;
                if (hs) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                bus.out_data = head;
                if (hs) begin
                    csum_d = csum_q ^ head;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == (len_q - 8'd1)) state_d = CSUM;
                end
            end
            CSUM: begin
                bus.out_data = csum_q;
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            len_q        <= 8'h00;
            cnt_q        <= 8'h00;
            csum_q       <= 8'h00;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
        end
    end

    assign fifo_level = level;
    assign overflow   = overflow_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_encrypt_packetizer.sv
// Directed bench for encrypt_packetizer (FIFO_DEPTH=16, PKT_LEN=8, SOF=A5).
module tb_encrypt_packetizer;
    import encrypt_config::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       clear_ovf = 1'b0;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       busy;
    pkt_state_t state_dbg;

    encrypt_packetizer_if bus();

    encrypt_packetizer #(
        .FIFO_DEPTH (16),
        .PKT_LEN    (8),
        .SOF_BYTE   (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flush      (flush),
        .clear_ovf  (clear_ovf),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    bit         toggle_mode = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [4:0] max_level = 5'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted frame byte must match the head of exp_q;
    // a stalled byte must be presented unchanged on the next cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (fifo_level > max_level) max_level = fifo_level;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_byte observed=%0h expected=none", bus.out_data);
                end
                if (exp_q.size() > 0) check("frame_byte", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_mode) bus.out_ready = ~bus.out_ready;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.din   = b;
        bus.din_v = 1'b1;
        tick();
        bus.din_v = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic exp_frame_01_08();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h08);
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h08);
    endtask

    initial begin
        bit found;
        logic [7:0] t5_bytes [8];

        bus.din       = 8'h00;
        bus.din_v     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'h00);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();

        // 1: one nominal frame, checksum 01^..^08 = 08
        exp_frame_01_08();
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        check("t1_level_at_n", 32'(fifo_level), 32'd8);
        check("t1_busy_at_n", 32'(busy), 32'd0);
        tick();
        check("t1_valid_n1", 32'(bus.out_valid), 32'd1);
        check("t1_sof_n1", 32'(bus.out_data), 32'hA5);
        check("t1_state_n1", 32'(state_dbg), 32'(SOF));
        wait_done(40, "t1_done");
        check("t1_level_end", 32'(fifo_level), 32'd0);

        // 2: same frame with out_ready toggling 1010..
        toggle_mode = 1'b1;
        bus.out_ready = 1'b1;
        exp_frame_01_08();
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        wait_done(80, "t2_done");
        toggle_mode = 1'b0;
        bus.out_ready = 1'b1;

        // 3: partial frame by flush; checksum 10^20^30 = 00
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h00);
        push_byte(8'h10);
        push_byte(8'h20);
        push_byte(8'h30);
        pulse_flush();
        wait_done(40, "t3_done");
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_empty_flush_idle", 32'(busy), 32'd0);
        end

        // 4: overflow while stalled; byte 50 is dropped
        bus.out_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h08);
            for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h40 + 8 * f + i));
            exp_q.push_back(8'h00);
        end
        for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i));
        check("t4_level_full", 32'(fifo_level), 32'd16);
        check("t4_no_ovf_yet", 32'(overflow), 32'd0);
        push_byte(8'h50);
        check("t4_ovf_set", 32'(overflow), 32'd1);
        check("t4_level_kept", 32'(fifo_level), 32'd16);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("t4_ovf_cleared", 32'(overflow), 32'd0);
        bus.out_ready = 1'b1;
        wait_done(80, "t4_done");
        check("t4_level_end", 32'(fifo_level), 32'd0);

        // 5: reset while the 3rd payload byte is presented
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h23);
        for (int i = 1; i <= 8; i++) push_byte(8'(8'h20 + i));
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state_dbg == PAYLOAD && bus.out_data == 8'h23) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reached_payload3", 32'(found), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_level", 32'(fifo_level), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        // checksum F0^0F^AA^55^12^34^56^79 = 09
        t5_bytes = '{8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h12, 8'h34, 8'h56, 8'h79};
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h08);
        for (int i = 0; i < 8; i++) exp_q.push_back(t5_bytes[i]);
        exp_q.push_back(8'h09);
        for (int i = 0; i < 8; i++) push_byte(t5_bytes[i]);
        wait_done(40, "t5_done");

        // 6: 24 back-to-back bytes -> three frames, checksums 08, 18, 08
        max_level = 5'd0;
        exp_frame_01_08();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h08);
        for (int i = 9; i <= 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h18);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h08);
        for (int i = 17; i <= 24; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h08);
        for (int i = 1; i <= 24; i++) push_byte(8'(i));
        wait_done(100, "t6_done");
        checks++;
        assert (max_level <= 5'd16) else begin
            failures++;
            $error("FAIL t6_level_max observed=%0d expected<=16", max_level);
        end
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_level_end", 32'(fifo_level), 32'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
